// File: rtl/ram_1r_1w_arbiter.sv
// Shares one 1R/1W RAM among REQUESTERS clients. The read and write ports
// each have their own round-robin arbiter. Both arbiters grant in the same
// cycle as the request. The combinational RAM read data is registered and
// tagged with the id of the winning client.
//
// Ports:
//   aClock, aReset              clock (rising edge), async active-high reset
//   aReadRequest/aReadAddress   per-client read request and address
//   anOutReadGrant              one-hot read grant (combinational)
//   anOutReadValid/Data/Id      registered read response, one cycle after grant
//   aWriteRequest/Address/Data  per-client write request, address and data
//   anOutWriteGrant             one-hot write grant (combinational)
//   anOutRamRead*, aRamReadData RAM read port (read data is combinational)
//   anOutRamWrite*              RAM write port (commits on the same edge)
module ram_1r_1w_arbiter #(
  parameter  int unsigned REQUESTERS = 4,
  parameter  int unsigned DEPTH      = 8,
  parameter  int unsigned SIZE       = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(SIZE),
  localparam int unsigned ID_WIDTH   = $clog2(REQUESTERS)
) (
  input  logic                                  aClock,
  input  logic                                  aReset,
  input  logic [REQUESTERS-1:0]                 aReadRequest,
  input  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] aReadAddress,
  output logic [REQUESTERS-1:0]                 anOutReadGrant,
  output logic                                  anOutReadValid,
  output logic [DEPTH-1:0]                      anOutReadData,
  output logic [ID_WIDTH-1:0]                   anOutReadId,
  input  logic [REQUESTERS-1:0]                 aWriteRequest,
  input  logic [REQUESTERS-1:0][ADDR_WIDTH-1:0] aWriteAddress,
  input  logic [REQUESTERS-1:0][DEPTH-1:0]      aWriteData,
  output logic [REQUESTERS-1:0]                 anOutWriteGrant,
  output logic [ADDR_WIDTH-1:0]                 anOutRamReadAddress,
  output logic                                  anOutRamReadEnable,
  input  logic [DEPTH-1:0]                      aRamReadData,
  output logic [ADDR_WIDTH-1:0]                 anOutRamWriteAddress,
  output logic [DEPTH-1:0]                      anOutRamWriteData,
  output logic                                  anOutRamWriteEnable
);

  // One extra bit so ptr + offset never overflows before the wrap compare.
  localparam int unsigned IDX_WIDTH = ID_WIDTH + 1;

  // Round-robin pick: returns {found, winner}, scanning upward from ptr.
  // Wrap uses an explicit compare so non-power-of-two counts work.
  function automatic logic [ID_WIDTH:0] rr_pick(
    input logic [REQUESTERS-1:0] req,
    input logic [ID_WIDTH-1:0]   ptr
  );
    logic [IDX_WIDTH-1:0] idx;
    logic                 found;
    logic [ID_WIDTH-1:0]  win;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      idx = IDX_WIDTH'(ptr) + IDX_WIDTH'(k);
      if (idx >= IDX_WIDTH'(REQUESTERS)) begin
        idx = idx - IDX_WIDTH'(REQUESTERS);
      end
      if (!found && req[idx[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_WIDTH-1:0];
      end
    end
    return {found, win};
  endfunction

  // Pointer moves to the slot after the winner, wrapping at REQUESTERS-1.
  function automatic logic [ID_WIDTH-1:0] ptr_after(input logic [ID_WIDTH-1:0] win);
    return (win == ID_WIDTH'(REQUESTERS - 1)) ? '0 : win + ID_WIDTH'(1);
  endfunction

  logic [ID_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ID_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DEPTH-1:0]    rd_data_q, rd_data_d;
  logic [ID_WIDTH-1:0] rd_id_q, rd_id_d;

  logic [ID_WIDTH:0]   rd_pick_c, wr_pick_c;
  logic                rd_found_c, wr_found_c;
  logic [ID_WIDTH-1:0] rd_win_c, wr_win_c;

  // Arbitration; grants are forced off while reset is asserted.
  always_comb begin
    rd_pick_c  = rr_pick(aReadRequest, rd_ptr_q);
    wr_pick_c  = rr_pick(aWriteRequest, wr_ptr_q);
    rd_found_c = rd_pick_c[ID_WIDTH] & ~aReset;
    wr_found_c = wr_pick_c[ID_WIDTH] & ~aReset;
    rd_win_c   = rd_pick_c[ID_WIDTH-1:0];
    wr_win_c   = wr_pick_c[ID_WIDTH-1:0];
  end

  // Grant and RAM port drive; everything idles to zero without a winner.
  always_comb begin
    anOutReadGrant       = '0;
    anOutWriteGrant      = '0;
    anOutRamReadEnable   = 1'b0;
    anOutRamReadAddress  = '0;
    anOutRamWriteEnable  = 1'b0;
    anOutRamWriteAddress = '0;
    anOutRamWriteData    = '0;
    if (rd_found_c) begin
      anOutReadGrant      = REQUESTERS'(1) << rd_win_c;
      anOutRamReadEnable  = 1'b1;
      anOutRamReadAddress = aReadAddress[rd_win_c];
    end
    if (wr_found_c) begin
      anOutWriteGrant      = REQUESTERS'(1) << wr_win_c;
      anOutRamWriteEnable  = 1'b1;
      anOutRamWriteAddress = aWriteAddress[wr_win_c];
      anOutRamWriteData    = aWriteData[wr_win_c];
    end
  end

  // Next-state: pointers advance on a grant; response captures the RAM word.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_id_d    = rd_id_q;
    if (rd_found_c) begin
      rd_ptr_d   = ptr_after(rd_win_c);
      rd_valid_d = 1'b1;
      rd_data_d  = aRamReadData;
      rd_id_d    = rd_win_c;
    end
    if (wr_found_c) begin
      wr_ptr_d = ptr_after(wr_win_c);
    end
  end

  // State registers; reset discards any in-flight read response.
  always_ff @(posedge aClock or posedge aReset) begin
    if (aReset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_id_q    <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_id_q    <= rd_id_d;
    end
  end

  assign anOutReadValid = rd_valid_q;
  assign anOutReadData  = rd_data_q;
  assign anOutReadId    = rd_id_q;

endmodule
